// File: rtl/snake_pkg.sv
// Shared types and ASCII helpers for the score UART transmitter.
// The byte values here are what the host terminal expects on the wire.
package snake_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} uart_tx_state_t;

  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_H     = 8'h48;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_QMARK = 8'h3F;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  // Non-decimal nibbles show up as '?' so a corrupted BCD value is visible on the host.
  function automatic logic [7:0] ascii_digit(input logic [3:0] digit);
    return (digit > 4'd9) ? CH_QMARK : (CH_ZERO + {4'h0, digit});
  endfunction

endpackage

// File: rtl/score_uart_tx.sv
// Sends "S:nn\r\n" / "H:nn\r\n" over a byte-wide UART port whenever a score report is requested.
// One request can wait while a line is in flight; newer requests replace it and are counted as drops.
module score_uart_tx
  import snake_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter bit SEND_CRLF  = 1'b1
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       report_i,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_ones,
  input  logic       game_over,
  input  logic       txready,
  output logic [7:0] txdata,
  output logic       txclk,
  output logic       busy,
  output logic [7:0] dropped
);

  localparam logic [2:0] LAST_IDX = SEND_CRLF ? 3'd5 : 3'd3;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  uart_tx_state_t state;
  logic [2:0]     idx;
  logic [GW-1:0]  gap_cnt;
  logic           last_sent;
  logic           pending;
  logic [3:0]     snap_tens, snap_ones;
  logic           snap_go;
  logic [3:0]     msg_tens, msg_ones;
  logic           msg_go;

  function automatic logic [7:0] byte_sel(input logic [2:0] i, input logic [3:0] tens,
                                          input logic [3:0] ones, input logic go);
    case (i)
      3'd0:    return go ? CH_H : CH_S;
      3'd1:    return CH_COLON;
      3'd2:    return ascii_digit(tens);
      3'd3:    return ascii_digit(ones);
      3'd4:    return CH_CR;
      3'd5:    return CH_LF;
      default: return CH_QMARK;
    endcase
  endfunction

  assign txclk = (state == SEND) & txready;
  assign busy  = (state != IDLE) | pending;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      gap_cnt   <= '0;
      last_sent <= 1'b0;
      pending   <= 1'b0;
      snap_tens <= 4'd0;
      snap_ones <= 4'd0;
      snap_go   <= 1'b0;
      msg_tens  <= 4'd0;
      msg_ones  <= 4'd0;
      msg_go    <= 1'b0;
      txdata    <= 8'h00;
      dropped   <= 8'd0;
    end else begin
      if (report_i) begin
        snap_tens <= bcd_tens;
        snap_ones <= bcd_ones;
        snap_go   <= game_over;
        // A pending request is only lost when it is not being taken up on this same edge.
        if (pending && (state != IDLE) && (dropped != 8'hFF)) dropped <= dropped + 8'd1;
      end

      if ((state == IDLE) && pending) pending <= report_i;
      else if (report_i)              pending <= 1'b1;

      case (state)
        IDLE: begin
          if (pending) begin
            state    <= SEND;
            idx      <= 3'd0;
            msg_tens <= snap_tens;
            msg_ones <= snap_ones;
            msg_go   <= snap_go;
            txdata   <= byte_sel(3'd0, snap_tens, snap_ones, snap_go);
          end
        end
        SEND: begin
          if (txready) begin
            state     <= GAP;
            gap_cnt   <= GAP_LOAD;
            last_sent <= (idx == LAST_IDX);
            if (idx != LAST_IDX) begin
              idx    <= idx + 3'd1;
              txdata <= byte_sel(idx + 3'd1, msg_tens, msg_ones, msg_go);
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= last_sent ? IDLE : SEND;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_uart_tx.sv
// Scoreboard bench for score_uart_tx: a line-level model queues expected bytes, a monitor pops them on txclk.
module tb_score_uart_tx;

  localparam int LEN = 6;
  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       report_i = 1'b0;
  logic [3:0] bcd_tens = 4'd0;
  logic [3:0] bcd_ones = 4'd0;
  logic       game_over = 1'b0;
  logic       txready = 1'b0;
  logic [7:0] txdata, dropped, txdata4, dropped4;
  logic       txclk, busy, txclk4, busy4;

  int vectors = 0;
  int miscompares = 0;
  int strobes = 0;

  logic [7:0] exp_q[$];
  logic [7:0] q4[$];
  logic [7:0] exp4 [0:3] = '{8'h53, 8'h3A, 8'h34, 8'h32};

  // Line-level reference state
  bit         m_active = 1'b0;
  bit         m_pend = 1'b0;
  int         m_left = 0;
  int         m_gap = 0;
  int         m_drops = 0;
  logic [7:0] m_pend_line [0:5];

  always #5 clk = ~clk;

  score_uart_tx #(.GAP_CYCLES(GAP), .SEND_CRLF(1'b1)) u_dut (
    .clk(clk), .nRst(nRst), .report_i(report_i), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .game_over(game_over), .txready(txready), .txdata(txdata), .txclk(txclk),
    .busy(busy), .dropped(dropped)
  );

  score_uart_tx #(.GAP_CYCLES(GAP), .SEND_CRLF(1'b0)) u_dut4 (
    .clk(clk), .nRst(nRst), .report_i(report_i), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .game_over(game_over), .txready(txready), .txdata(txdata4), .txclk(txclk4),
    .busy(busy4), .dropped(dropped4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc_digit(input logic [3:0] d);
    return (d <= 4'd9) ? (8'd48 + 8'(d)) : 8'd63;
  endfunction

  // Monitor + model: at each falling edge, judge what the coming rising edge does.
  initial begin : monitor
    bit exp_strobe;
    bit start;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        m_active = 1'b0; m_pend = 1'b0; m_left = 0; m_gap = 0; m_drops = 0;
        exp_q.delete();
      end else begin
        check("busy", busy, 32'(m_active || m_pend));
        check("dropped", dropped, m_drops);
        exp_strobe = m_active && (m_gap == 0) && (m_left > 0) && txready;
        check("txclk", txclk, 32'(exp_strobe));
        if (txclk) begin
          strobes++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL txdata: got %02h, expected no byte (t=%0t)", txdata, $time);
          end else begin
            e = exp_q.pop_front();
            check("txdata", txdata, e);
            $display("tx byte %02h expected %02h t=%0t", txdata, e, $time);
          end
        end
        start = !m_active && m_pend;
        if (m_active) begin
          if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0 && m_left == 0) m_active = 1'b0;
          end else if (exp_strobe) begin
            m_left--;
            m_gap = GAP;
          end
        end else if (start) begin
          for (int i = 0; i < LEN; i++) exp_q.push_back(m_pend_line[i]);
          m_active = 1'b1; m_left = LEN; m_gap = 0; m_pend = 1'b0;
        end
        if (report_i) begin
          if (m_pend && m_drops < 255) m_drops++;
          m_pend = 1'b1;
          m_pend_line[0] = game_over ? 8'h48 : 8'h53;
          m_pend_line[1] = 8'h3A;
          m_pend_line[2] = enc_digit(bcd_tens);
          m_pend_line[3] = enc_digit(bcd_ones);
          m_pend_line[4] = 8'h0D;
          m_pend_line[5] = 8'h0A;
        end
      end
    end
  end

  initial begin : monitor4
    forever begin
      @(negedge clk);
      if (nRst && txclk4) q4.push_back(txdata4);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic report(input logic [3:0] t, input logic [3:0] o, input logic g);
    report_i = 1'b1; bcd_tens = t; bcd_ones = o; game_over = g;
    tick();
    report_i = 1'b0;
    bcd_tens = 4'($urandom); bcd_ones = 4'($urandom); game_over = 1'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((busy || exp_q.size() != 0) && c < budget) begin tick(); c++; end
    if (busy || exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: busy=%0b queue=%0d after %0d cycles", busy, exp_q.size(), budget);
    end
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int c = 0;
    while (strobes < target && c < budget) begin tick(); c++; end
    if (strobes < target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_strobes: got %0d, expected %0d", strobes, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txdata"}, txdata, 8'h00);
    check({tag, "_txclk"}, txclk, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_dropped"}, dropped, 8'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s0;
    int b4;
    tick(2);
    check_reset_outputs("reset_held");
    nRst = 1'b1;
    tick();
    check_reset_outputs("reset_released");

    // Basic line, and the 4-byte variant alongside it
    txready = 1'b1;
    s0 = strobes; b4 = q4.size();
    report(4'd4, 4'd2, 1'b0);
    wait_idle(100);
    check("basic_strobes", strobes - s0, LEN);
    check("crlf0_strobes", q4.size() - b4, 4);
    for (int i = 0; i < 4; i++)
      if (b4 + i < q4.size()) check("crlf0_byte", q4[b4 + i], exp4[i]);
    check("crlf0_busy", busy4, 1'b0);

    // Backpressure after byte0 is accepted
    s0 = strobes;
    report(4'd4, 4'd2, 1'b0);
    wait_strobes(s0 + 1, 50);
    txready = 1'b0;
    tick(10);
    check("stall_txdata", txdata, 8'h3A);
    check("stall_txclk", txclk, 1'b0);
    txready = 1'b1;
    wait_idle(100);
    check("stall_strobes", strobes - s0, LEN);

    // Overwrite while stalled
    txready = 1'b0;
    report(4'd1, 4'd2, 1'b0);
    tick(2);
    report(4'd3, 4'd4, 1'b0);
    report(4'd5, 4'd0, 1'b1);
    check("overwrite_dropped", dropped, 8'd1);
    txready = 1'b1;
    wait_idle(100);

    // Non-decimal tens digit
    report(4'hA, 4'd3, 1'b1);
    wait_idle(100);

    // Request lands on the edge that accepts the last byte
    s0 = strobes;
    report(4'd6, 4'd1, 1'b0);
    tick(11);
    report(4'd9, 4'd9, 1'b1);
    wait_idle(100);
    check("b2b_strobes", strobes - s0, 2 * LEN);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      txready = ($urandom_range(0, 9) != 0);
      report_i = ($urandom_range(0, 14) == 0);
      bcd_tens = 4'($urandom); bcd_ones = 4'($urandom); game_over = 1'($urandom);
      tick();
    end
    report_i = 1'b0;
    txready = 1'b1;
    wait_idle(400);

    // Reset in the middle of a line
    s0 = strobes;
    report(4'd4, 4'd2, 1'b0);
    wait_strobes(s0 + 3, 50);
    nRst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick(2);
    nRst = 1'b1;
    tick();
    s0 = strobes;
    report(4'd7, 4'd9, 1'b1);
    wait_idle(100);
    check("fresh_strobes", strobes - s0, LEN);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
